// File: rtl/spi_bus_sequencer_pkg.sv
// Shared definitions for the SPI bus sequencer.
// Contents: frame geometry, access-type encodings, bit positions within the
// 16-bit slave frame, the FSM state type and the frame-build helper.
// Frame index = transmit order: bit 0 leaves the master first.
package spi_bus_pkg;

  localparam int FRAME_LEN = 16;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int POS_RW   = 0;
  localparam int POS_EXT  = 1;
  localparam int POS_RSVD = 4;
  localparam int POS_REG  = 5;
  localparam int POS_DATA = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  // Address fields go out LSB first, write data MSB first; the data field
  // is all zeros for reads so the slave sees a quiet mosi while it answers.
  function automatic logic [FRAME_LEN-1:0] build_frame(
    input logic       rw,
    input logic [2:0] ext,
    input logic [2:0] rg,
    input logic [7:0] wd
  );
    logic [FRAME_LEN-1:0] f;
    f = '0;
    f[POS_RW]   = rw;
    f[POS_RSVD] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f[POS_EXT + i] = ext[i];
      f[POS_REG + i] = rg[i];
    end
    for (int i = 0; i < 8; i++) begin
      f[POS_DATA + i] = (rw == RW_WRITE) ? wd[7 - i] : 1'b0;
    end
    return f;
  endfunction

endpackage

// File: rtl/spi_bus_sequencer_if.sv
// Interface bundling the requester-side handshake and the SPI slave bus of
// the sequencer.
//   master modport: the sequencer (takes requests + miso, drives grant/done/
//                   rdata/err/busy and cs/mosi).
//   slave modport : the environment (requesters and the addressed slave).
// Per-requester fields are packed: requester i at ext_addr[3i+2:3i],
// reg_addr[3i+2:3i], wdata[8i+7:8i], bit i of req/rw/grant/done.
interface spi_bus_sequencer_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   rw;
  logic [3*NUM_REQ-1:0] ext_addr;
  logic [3*NUM_REQ-1:0] reg_addr;
  logic [8*NUM_REQ-1:0] wdata;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic [7:0]           rdata;
  logic                 err;
  logic                 busy;
  logic                 cs;
  logic                 mosi;
  logic                 miso;
  logic                 miso_oe;

  modport master (
    input  req, rw, ext_addr, reg_addr, wdata, miso, miso_oe,
    output grant, done, rdata, err, busy, cs, mosi
  );

  modport slave (
    output req, rw, ext_addr, reg_addr, wdata, miso, miso_oe,
    input  grant, done, rdata, err, busy, cs, mosi
  );

endinterface

// File: rtl/spi_bus_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     in  NUM_REQ  request levels
//   ptr     in  IDX_W    index of the requester served last
//   winner  out NUM_REQ  one-hot winner (all zero when no request)
//   win_idx out IDX_W    index of the winner (0 when no request)
// Search starts one past ptr and wraps, so the last-served requester has the
// lowest priority.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   win_idx
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found   = 1'b0;
    cand    = '0;
    winner  = '0;
    win_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found         = 1'b1;
        winner[cand]  = 1'b1;
        win_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/spi_bus_sequencer.sv
// SPI bus sequencer: shares one SPI slave bus among NUM_REQ requesters.
// Ports:
//   sclk  in   bus/system clock, all logic on posedge
//   rst   in   synchronous active-high reset
//   bus   master modport of spi_bus_sequencer_if (requests, grant/done,
//         rdata/err/busy, cs/mosi/miso/miso_oe)
// A granted request is serialised into a 16-bit frame with cs high for
// exactly 16 cycles; done pulses the cycle after cs drops, then at least
// GAP_CYCLES idle cycles follow before the next grant.
module spi_bus_sequencer
  import spi_bus_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic               sclk,
  input logic               rst,
  spi_bus_sequencer_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [3:0]           cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 cs_q;
  logic                 mosi_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [7:0]           rdata_q;
  logic                 err_q;
  logic                 busy_q;

  // Datapath registers: only meaningful inside a frame, so never reset.
  logic [FRAME_LEN-2:0] shreg;
  logic                 rw_lat;
  logic [6:0]           cap;
  logic                 err_acc;

  logic [2:0]           ext_arr [NUM_REQ];
  logic [2:0]           reg_arr [NUM_REQ];
  logic [7:0]           wd_arr  [NUM_REQ];

  logic [NUM_REQ-1:0]   win_onehot;
  logic [IDX_W-1:0]     win_idx;
  logic [FRAME_LEN-1:0] win_frame;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign ext_arr[g] = bus.ext_addr[3*g +: 3];
    assign reg_arr[g] = bus.reg_addr[3*g +: 3];
    assign wd_arr[g]  = bus.wdata[8*g +: 8];
  end

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (bus.req),
    .ptr     (ptr),
    .winner  (win_onehot),
    .win_idx (win_idx)
  );

  assign win_frame = build_frame(bus.rw[win_idx], ext_arr[win_idx],
                                 reg_arr[win_idx], wd_arr[win_idx]);

  always_ff @(posedge sclk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= IDX_W'(NUM_REQ - 1);
      cnt     <= '0;
      gap_cnt <= '0;
      cs_q    <= 1'b0;
      mosi_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            // Bit 0 goes straight to mosi; shreg keeps bits 1..15 so that
            // shreg[0] always holds the next bit to transmit.
            shreg   <= win_frame[FRAME_LEN-1:1];
            rw_lat  <= bus.rw[win_idx];
            cs_q    <= 1'b1;
            mosi_q  <= win_frame[POS_RW];
            grant_q <= win_onehot;
            cnt     <= '0;
            ptr     <= win_idx;
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          // Data-bit window: miso sampled at the edge ending each bit cycle.
          if (cnt >= 4'(POS_DATA)) begin
            cap     <= {cap[5:0], bus.miso};
            err_acc <= (cnt == 4'(POS_DATA)) ? !bus.miso_oe
                                              : (err_acc | !bus.miso_oe);
          end
          if (cnt == 4'(FRAME_LEN - 1)) begin
            cs_q    <= 1'b0;
            mosi_q  <= 1'b0;
            grant_q <= '0;
            done_q  <= grant_q;
            if (rw_lat == RW_READ) begin
              rdata_q <= {cap, bus.miso};
              err_q   <= err_acc | !bus.miso_oe;
            end else begin
              err_q   <= 1'b0;
            end
            gap_cnt <= '0;
            state   <= GAP;
          end else begin
            cnt    <= cnt + 1'b1;
            mosi_q <= shreg[0];
            shreg  <= {1'b0, shreg[FRAME_LEN-2:1]};
          end
        end

        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cs    = cs_q;
  assign bus.mosi  = mosi_q;
  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: doc/spi_bus_sequencer.md
Name: spi_bus_sequencer

Overview:
- Master-side controller that shares one SPI slave bus (`cs`/`mosi`/`miso`/`miso_oe`) among NUM_REQ on-chip requesters.
- Arbitrates requesters round-robin, serialises each granted request into the 16-bit slave frame, drives `cs`/`mosi`, and captures read data from `miso`.
- Sits between the register-access clients and the bank of addressed SPI slaves; all slaves share the same `sclk`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 1, idle cycles forced after every frame (minimum 1).

Ports:
- sclk  in  1  bus/system clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- req  in  NUM_REQ  per-requester request level; held until its done pulse.
- rw  in  NUM_REQ  per-requester access type: 1=write, 0=read.
- ext_addr  in  3*NUM_REQ  per-requester slave select address, requester i at [3i+2:3i].
- reg_addr  in  3*NUM_REQ  per-requester register address.
- wdata  in  8*NUM_REQ  per-requester write data, requester i at [8i+7:8i].
- grant  out  NUM_REQ  one-hot; high for the whole frame of the served requester.
- done  out  NUM_REQ  one-cycle completion pulse to the served requester.
- rdata  out  8  read data of the last completed read; valid while done is high.
- err  out  1  qualifies done: read saw `miso_oe` low on any data bit.
- busy  out  1  high while state != IDLE.
- cs  out  1  slave chip select, active-high.
- mosi  out  1  serial data to slaves.
- miso  in  1  serial data from the addressed slave.
- miso_oe  in  1  addressed slave is driving miso.

Behaviour:
- Reset values:
  - `cs`, `mosi`, `grant`, `done`, `rdata`, `err`, `busy` = 0.
  - State = IDLE; round-robin pointer = NUM_REQ-1, so requester 0 has highest priority first.
- Frame layout, 16 bits, index = transmit order:
  - [0] rw.
  - [1..3] ext_addr[0..2], LSB first.
  - [4] reserved, 0.
  - [5..7] reg_addr[0..2], LSB first.
  - [8..15] wdata[7..0], MSB first. Driven as 0 for reads.
- States:
  - IDLE: if any `req`, pick the winner and latch its fields into a 16-bit shift register. On that same edge: `cs`<=1, `mosi`<=frame[0], `grant`<=one-hot winner, bit counter <=0, pointer <=winner, go to SHIFT. No req: stay.
  - SHIFT: each posedge, counter+1 and `mosi`<=frame[counter+1]. `cs` stays high for exactly 16 cycles, one bit per cycle.
  - On the edge ending counter=15: `cs`<=0, `mosi`<=0, `grant`<=0, `done[winner]`<=1 for one cycle, `rdata`/`err` updated, go to GAP.
  - GAP: count GAP_CYCLES cycles, then IDLE. Result: `cs` low for at least GAP_CYCLES+1 cycles between frames.
- Latency: req seen in IDLE in cycle t; `cs` high in cycles t+1..t+16; done in cycle t+17.
- Read capture:
  - At the posedge ending each data-bit cycle (counter 8..15), shift `miso` in, MSB first: counter 8 -> rdata[7], counter 15 -> rdata[0].
  - In the same window, sticky-OR `!miso_oe` into the error flag.
  - `rdata` and `err` are written only at frame end. Writes leave `rdata` unchanged and set `err`=0.
- Round robin: the search starts at pointer+1, modulo NUM_REQ. A requester that keeps `req` asserted is re-served only after every other active requester has been served once.
- Requester fields are sampled only at grant. Later changes, including dropping `req` mid-frame, do not affect the frame. It completes and `done` still pulses.
- A requester must drop `req` within GAP_CYCLES cycles of `done`, otherwise it is treated as a new request.
- Reset mid-frame: on the reset edge, `cs`/`mosi`/`grant` go to 0 and the state goes to IDLE. No `done` pulse; the pointer is reset.
- A req arriving during SHIFT or GAP waits; there is no preemption.

Decomposition:
- Shared package spi_bus_pkg:
  - FRAME_LEN=16, RW_WRITE=1, RW_READ=0.
  - Bit-position constants: POS_RW=0, POS_EXT=1, POS_RSVD=4, POS_REG=5, POS_DATA=8.
  - State encoding: IDLE, SHIFT, GAP.
  - Frame-build function used by both RTL and bench.
- One sub-module: spi_rr_arbiter. Inputs: req vector and pointer. Outputs: one-hot winner and its index. Purely combinational.

Test Plan:
- Write, requester 0, ext=7, reg=7, wdata=0xAD -> `mosi` during `cs` reads 1,1,1,1,0,1,1,1,1,0,1,0,1,1,0,1; `cs` high exactly 16 cycles; `done[0]` in cycle t+17; `err`=0.
- Read, requester 1, ext=2, reg=5; slave model drives `miso_oe`=1 and 0x5A on data bits -> header bits 0,0,1,0,0,1,0,1 then 8 zeros; `rdata`=0x5A and `err`=0 with `done[1]`.
- Read with no responding slave (`miso_oe`=0, `miso`=0) -> `done` pulses, `err`=1, `rdata`=0x00.
- All 4 requests asserted together after reset, each dropping after its done -> grant order 0,1,2,3. Then requesters 0 and 2 held continuously -> grants alternate 0,2,0,2. `cs` low ≥2 cycles between frames with GAP_CYCLES=1.
- Assert `rst` while counter=5 -> `cs`/`mosi`/`grant` 0 next cycle, no `done`. A new request afterwards produces a complete fresh 16-bit frame.
- Requester drops `req` and changes wdata at counter=10 -> frame still carries the latched wdata; `done` pulses once; no frame is restarted for it.
